l2_line_fill: RTL

L2_LINE_FILL -- requirements
Module: l2_line_fill

---
 rtl/l2_line_fill.sv | 112 +++++++++++
 1 files changed

// File: rtl/l2_line_fill.sv
// L2 line fill: assembles a 256-bit line from a four-beat 64-bit memory burst.
// Define L2_FILL_CWF_EN to fetch the critical word first and wrap around the line.
module l2_line_fill #(
    parameter int s_offset = 5,
    parameter int s_index  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fill_req,
    input  logic [31:0]               fill_addr,
    output logic                      fill_ready,
    output logic [2**s_offset*8-1:0]  fill_line,
    output logic [2**s_offset-1:0]    fill_wmask,
    output logic [s_index-1:0]        fill_index,
    output logic                      busy,
    output logic                      mem_read,
    output logic [31:0]               mem_addr,
    input  logic [63:0]               mem_rdata,
    input  logic                      mem_resp
);

    localparam int LW = 2**s_offset*8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [31:0]     addr_q;
    logic [1:0]      beat_q;
    logic [1:0]      cnt_q;
    logic [LW-1:0]   line_q;
    logic            ready_q;
    logic            read_q;
    logic            busy_q;
    logic [1:0]      beat_start;
    logic            unused_addr;

`ifdef L2_FILL_CWF_EN
    assign beat_start = fill_addr[4:3];
    assign mem_addr   = {addr_q[31:3], 3'b000};
`else
    assign beat_start = 2'd0;
    assign mem_addr   = {addr_q[31:s_offset], {s_offset{1'b0}}};
`endif

    assign unused_addr = ^addr_q[s_offset-1:0];

    assign fill_ready = ready_q;
    assign fill_wmask = {(2**s_offset){ready_q}};
    assign fill_line  = line_q;
    assign fill_index = addr_q[s_offset +: s_index];
    assign busy       = busy_q;
    assign mem_read   = read_q;

    // beat_q picks the slot, cnt_q counts accepted beats independent of wrap start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
            ready_q <= 1'b0;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fill_req) begin
                        state_q <= FETCH;
                        addr_q  <= fill_addr;
                        beat_q  <= beat_start;
                        cnt_q   <= 2'd0;
                        read_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_resp) begin
                        for (int b = 0; b < 4; b++) begin
                            if (beat_q == 2'(b)) begin
                                line_q[64*b +: 64] <= mem_rdata;
                            end
                        end
                        beat_q <= beat_q + 2'd1;
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= DONE;
                            read_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    read_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
